// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 16x oversampling, optional parity, 1-2 stop bits, valid/ready output.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote over ticks 7, 8 and 9.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic PAR_INV = (PARITY == 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DECIDE_AT = 4'd8;
`else
    localparam logic [3:0] DECIDE_AT = 4'd7;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state, state_next;
    logic                   sync1, sync2, sync3;
    logic                   rx_sync, start_edge;
    logic [TW-1:0]          tick_cnt;
    logic [3:0]             tick_idx;
    logic                   tick, decide, bit_end, bit_val;
    logic                   restart, frame_done;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_err_p, frm_err_p, frm_err_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rs232_rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_sync    = sync2;
    assign start_edge = sync3 & ~sync2;

    // Tick phase is re-zeroed on every start edge so sampling lands mid-bit.
    assign tick    = (tick_cnt == TICK_LAST);
    assign decide  = tick && (tick_idx == DECIDE_AT);
    assign bit_end = tick && (tick_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            tick_cnt <= '0;
            tick_idx <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            tick_idx <= tick_idx + 4'd1;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp_a, samp_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (tick && tick_idx == 4'd6) begin
            samp_a <= rx_sync;
        end else if (tick && tick_idx == 4'd7) begin
            samp_b <= rx_sync;
        end
    end

    assign bit_val = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        restart    = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (start_edge) begin
                       state_next = START;
                       restart    = 1'b1;
                   end
            START: if (decide && bit_val) state_next = IDLE;
                   else if (bit_end)      state_next = DATA;
            DATA:  if (bit_end && bit_cnt == LAST_DATA)
                       state_next = (PARITY != 0) ? PAR : STOP;
            PAR:   if (bit_end) state_next = STOP;
            STOP:  if (decide && bit_cnt == LAST_STOP) begin
                       state_next = IDLE;
                       frame_done = 1'b1;
                   end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_err_p <= 1'b0;
            frm_err_p <= 1'b0;
        end else if (restart) begin
            bit_cnt   <= '0;
            par_err_p <= 1'b0;
            frm_err_p <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (decide)  shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                    if (bit_end) bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
                end
                PAR:  if (decide) par_err_p <= bit_val ^ (^shift_reg) ^ PAR_INV;
                STOP: begin
                    if (decide && !bit_val) frm_err_p <= 1'b1;
                    if (bit_end)            bit_cnt   <= bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // The last stop bit is judged in the same cycle the frame completes.
    assign frm_err_now = frm_err_p | ~bit_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift_reg;
                    frame_err  <= frm_err_now;
                    parity_err <= par_err_p;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three configurations (8N1 slow, 8E1 fast, 8O2 fast),
// directed frames plus randomised traffic checked against a frame-level reference model.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 50000000;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        bit         chk_time;
        int         rise;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       line_w    [3];
    logic       ready_w   [3];
    logic [7:0] data_w    [3];
    logic       valid_w   [3];
    logic       ferr_w    [3];
    logic       perr_w    [3];
    logic       ovr_w     [3];
    logic       busy_w    [3];

    bit         hold_ready [3];
    bit         rand_mode  [3];
    bit         prev_valid [3];
    bit         prev_ready [3];
    bit         prev_ovr   [3];
    logic [9:0] prev_word  [3];
    int         rise_cnt   [3];
    int         ovr_cnt    [3];
    int         exp_ovr    [3];
    int         wide_cnt;
    int         cyc;
    int         total;
    int         bad;
    exp_t       exp_q [$];

    int div_cfg   [3];
    int par_cfg   [3];
    int stop_cfg  [3];

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .rs232_rx(line_w[0]), .rx_data(data_w[0]), .rx_valid(valid_w[0]),
        .rx_ready(ready_w[0]), .frame_err(ferr_w[0]), .parity_err(perr_w[0]), .overrun(ovr_w[0]),
        .rx_busy(busy_w[0]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .rs232_rx(line_w[1]), .rx_data(data_w[1]), .rx_valid(valid_w[1]),
        .rx_ready(ready_w[1]), .frame_err(ferr_w[1]), .parity_err(perr_w[1]), .overrun(ovr_w[1]),
        .rx_busy(busy_w[1]));

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(1000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .rs232_rx(line_w[2]), .rx_data(data_w[2]), .rx_valid(valid_w[2]),
        .rx_ready(ready_w[2]), .frame_err(ferr_w[2]), .parity_err(perr_w[2]), .overrun(ovr_w[2]),
        .rx_busy(busy_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready changes just after the rising edge so the negedge monitor sees a settled value.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                ready_w[i] = rand_mode[i] ? 1'($urandom_range(0, 1)) : 1'(hold_ready[i]);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (valid_w[i] && !prev_valid[i]) begin
                rise_cnt[i]++;
                checkOutput("valid_has_expect", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0 && exp_q[0].id == 2'(i) && exp_q[0].chk_time)
                    checkOutput("valid_latency", 32'(cyc), 32'(exp_q[0].rise));
            end
            if (prev_valid[i] && !prev_ready[i] && valid_w[i])
                checkOutput("hold_stable", 32'({data_w[i], ferr_w[i], perr_w[i]}), 32'(prev_word[i]));
            if (valid_w[i] && ready_w[i]) begin
                checkOutput("frame_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("frame", 32'({2'(i), data_w[i], ferr_w[i], perr_w[i]}),
                                32'({e.id, e.data, e.ferr, e.perr}));
                end
            end
            if (ovr_w[i]) begin
                ovr_cnt[i]++;
                if (prev_ovr[i]) wide_cnt++;
            end
            prev_ovr[i]   = ovr_w[i];
            prev_valid[i] = valid_w[i];
            prev_ready[i] = ready_w[i];
            prev_word[i]  = {data_w[i], ferr_w[i], perr_w[i]};
        end
    end

    // Sends one frame; stop_mask bit s drives stop bit s low, par_force < 0 sends the correct parity.
    task automatic applyStimulus(input int id, input logic [7:0] data, input int par_force,
                                 input int stop_mask, input bit chk_time, input bit expect_frame,
                                 input int gap_bits);
        exp_t e;
        int   bclk;
        int   nb;
        bit   p_model;
        bit   p_sent;
        bclk    = 16 * div_cfg[id];
        p_model = (par_cfg[id] == 2) ? ($countones(data) % 2 == 1) : ($countones(data) % 2 == 0);
        p_sent  = (par_force < 0) ? p_model : (par_force != 0);
        nb      = 1 + 8 + ((par_cfg[id] != 0) ? 1 : 0) + stop_cfg[id] - 1;
        @(negedge clk);
        e.id       = 2'(id);
        e.data     = data;
        e.ferr     = (stop_mask != 0);
        e.perr     = (par_cfg[id] != 0) && (p_sent != p_model);
        e.chk_time = chk_time;
        // Two synchroniser clocks, then whole ticks up to the decision tick of the last stop bit.
        e.rise     = cyc + 1 + 2 + div_cfg[id] * (16 * nb + 8);
`ifdef UART_RX_MAJORITY_EN
        e.rise     = e.rise + div_cfg[id];
`endif
        if (expect_frame) exp_q.push_back(e);
        line_w[id] = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            line_w[id] = data[b];
            repeat (bclk) @(negedge clk);
        end
        if (par_cfg[id] != 0) begin
            line_w[id] = p_sent;
            repeat (bclk) @(negedge clk);
        end
        for (int s = 0; s < stop_cfg[id]; s++) begin
            line_w[id] = !stop_mask[s];
            repeat (bclk) @(negedge clk);
        end
        line_w[id] = 1'b1;
        repeat (bclk * gap_bits) @(negedge clk);
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int r0;
        int id;
        int pf;
        int sm;
        int gap;
        logic [7:0] rd;
        logic [7:0] partial;

        div_cfg  = '{CLK_FREQ / (115200 * 16), CLK_FREQ / (1000000 * 16), CLK_FREQ / (1000000 * 16)};
        par_cfg  = '{0, 2, 1};
        stop_cfg = '{1, 1, 2};
        total    = 0;
        bad      = 0;
        wide_cnt = 0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            line_w[i]     = 1'b1;
            hold_ready[i] = 1'b1;
            rand_mode[i]  = 1'b0;
            exp_ovr[i]    = 0;
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            checkOutput("reset_outputs",
                        32'({data_w[i], valid_w[i], ferr_w[i], perr_w[i], ovr_w[i], busy_w[i]}), 32'd0);

        $display("[TB] 0xA5 8N1 with latency check");
        applyStimulus(0, 8'hA5, -1, 0, 1'b1, 1'b1, 1);
        waitDrain(200);

        $display("[TB] 0xC3 with parity bit forced to 1, even then odd");
        applyStimulus(1, 8'hC3, 1, 0, 1'b0, 1'b1, 1);
        applyStimulus(2, 8'hC3, 1, 0, 1'b0, 1'b1, 1);
        waitDrain(200);

        $display("[TB] 0x3C with low stop bit");
        applyStimulus(0, 8'h3C, -1, 1, 1'b0, 1'b1, 1);
        waitDrain(200);

        $display("[TB] overrun: 0x11 then 0x22 with ready held low");
        hold_ready[0] = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(0, 8'h11, -1, 0, 1'b0, 1'b1, 1);
        applyStimulus(0, 8'h22, -1, 0, 1'b0, 1'b0, 1);
        exp_ovr[0]++;
        checkOutput("held_data", 32'(data_w[0]), 32'h11);
        checkOutput("overrun_count_dut0", 32'(ovr_cnt[0]), 32'(exp_ovr[0]));
        hold_ready[0] = 1'b1;
        waitDrain(200);

        $display("[TB] 100-clock glitch on idle line");
        @(negedge clk);
        r0 = rise_cnt[0];
        line_w[0] = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("glitch_busy_seen", 32'(busy_w[0]), 32'd1);
        repeat (50) @(negedge clk);
        line_w[0] = 1'b1;
        repeat (16 * div_cfg[0] - 100) @(negedge clk);
        checkOutput("glitch_busy_low", 32'(busy_w[0]), 32'd0);
        checkOutput("glitch_no_valid", 32'(rise_cnt[0]), 32'(r0));

        $display("[TB] reset asserted during data bit 4");
        partial = 8'h96;
        @(negedge clk);
        line_w[0] = 1'b0;
        repeat (16 * div_cfg[0]) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            line_w[0] = partial[b];
            repeat (16 * div_cfg[0]) @(negedge clk);
        end
        line_w[0] = partial[4];
        repeat (8 * div_cfg[0]) @(negedge clk);
        rst       = 1'b1;
        line_w[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_valid", 32'(valid_w[0]), 32'd0);
        checkOutput("post_reset_idle", 32'(busy_w[0]), 32'd0);
        repeat (16 * div_cfg[0]) @(negedge clk);
        applyStimulus(0, 8'h5A, -1, 0, 1'b0, 1'b1, 1);
        waitDrain(200);

        $display("[TB] randomised frames on parity configurations");
        rand_mode[1] = 1'b1;
        rand_mode[2] = 1'b1;
        for (int n = 0; n < 14; n++) begin
            id  = $urandom_range(1, 2);
            rd  = 8'($urandom);
            pf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
            sm  = ($urandom_range(0, 4) == 0) ? (1 << $urandom_range(0, stop_cfg[id] - 1)) : 0;
            gap = sm[stop_cfg[id] - 1] ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            applyStimulus(id, rd, pf, sm, 1'b0, 1'b1, gap);
        end
        rand_mode[1] = 1'b0;
        rand_mode[2] = 1'b0;
        repeat (4) @(negedge clk);
        waitDrain(400);

        for (int i = 0; i < 3; i++)
            checkOutput("overrun_count", 32'(ovr_cnt[i]), 32'(exp_ovr[i]));
        checkOutput("overrun_width", 32'(wide_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame, legal range 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame, legal values 1 or 2.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-008 The block SHALL have port rs232_rx, input, 1 bit, meaning the asynchronous serial line, idle high.
REQ-009 The block SHALL have port rx_data, output, DATA_BITS bits, meaning the received payload, LSB first on the line.
REQ-010 The block SHALL have port rx_valid, output, 1 bit, meaning rx_data and the error flags hold an unconsumed frame.
REQ-011 The block SHALL have port rx_ready, input, 1 bit, meaning the consumer accepts the frame on a cycle where rx_valid and rx_ready are both high.
REQ-012 The block SHALL have port frame_err, output, 1 bit, meaning the held frame had a low stop bit.
REQ-013 The block SHALL have port parity_err, output, 1 bit, meaning the held frame failed the parity check; it is always 0 when PARITY=0.
REQ-014 The block SHALL have port overrun, output, 1 bit, meaning a one-cycle pulse that a frame was dropped.
REQ-015 The block SHALL have port rx_busy, output, 1 bit, meaning the state machine is not in IDLE.

Function
REQ-016 The block SHALL pass rs232_rx through a 2-flop synchroniser followed by one edge-detect flop; a start is detected on a registered 1-to-0 transition.
REQ-017 The block SHALL generate an internal 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks, using integer truncation with DIV of at least 1.
REQ-018 The tick counter SHALL be restarted on start detection, so that frame timing is phase-aligned to the edge.
REQ-019 The state machine SHALL have states IDLE, START, DATA, PAR, STOP and SHALL traverse IDLE->START->DATA->(PAR if PARITY!=0)->STOP->IDLE.
REQ-020 Each bit SHALL occupy 16 ticks, and the bit value SHALL be taken at tick 8 of the bit.
REQ-021 In START, if the sampled value at tick 8 is high, the block SHALL treat it as a false start and return to IDLE with no output and no flags.
REQ-022 DATA SHALL shift in exactly DATA_BITS bits LSB first, using a bit counter wide enough for 9.
REQ-023 PAR SHALL compare the received parity bit against the XOR of the data bits, inverted for odd parity; a mismatch sets the pending parity error.
REQ-024 STOP SHALL sample STOP_BITS stop bits, and any low stop bit SHALL set the pending framing error.
REQ-025 The block SHALL return to IDLE at tick 8 of the last stop bit, i.e. half a bit early, so that back-to-back frames are not missed.
REQ-026 At the completion of a frame with rx_valid low, the block SHALL load rx_data, frame_err and parity_err and set rx_valid on the next clock.
REQ-027 The latency from the mid-point of the last stop bit to rx_valid high SHALL be exactly 1 clock.
REQ-028 rx_valid SHALL stay high, with rx_data and the flags stable, until a cycle with rx_ready high, after which it clears on the next clock.
REQ-029 If a frame completes while rx_valid is high and rx_ready is low, the new frame SHALL be discarded, the held frame kept, and overrun pulsed for 1 clock.
REQ-030 If a frame completes in the same cycle as a handshake, the new frame SHALL be loaded, rx_valid SHALL stay high, and overrun SHALL stay low.
REQ-031 A frame with frame_err set SHALL still be delivered to the consumer.
REQ-032 If the line stays low after a framing error, the block SHALL NOT detect a new start until it has seen a high level.

Reset
REQ-033 While rst is high on a clock edge, the block SHALL set the state to IDLE, clear all counters, set rx_data to 0, and drive rx_valid, frame_err, parity_err, overrun and rx_busy low.
REQ-034 While rst is high, the synchroniser flops SHALL be set to 1 (idle line).
REQ-035 Reset asserted mid-frame SHALL abandon the partial frame with no output.
REQ-036 After reset the block SHALL require a fresh falling edge before it starts a new frame.

Configuration
REQ-037 With macro UART_RX_MAJORITY_EN defined, each bit value SHALL be the 2-of-3 majority of the samples at ticks 7, 8 and 9, with the decision made at tick 9, and REQ-025 SHALL then return to IDLE at tick 9.
REQ-038 Without UART_RX_MAJORITY_EN, the block SHALL use a single sample at tick 8, and no majority logic SHALL be synthesised.

Verification
REQ-039 The bench SHALL send 0xA5 at 8N1 with CLK_FREQ=50e6 and BAUD=115200 (DIV=27, 432 clk/bit) and SHALL require rx_data=0xA5, rx_valid high 1 clock after the stop mid-point, and no error flags.
REQ-040 The bench SHALL send a 0xC3 frame with PARITY=2 and the parity bit forced to 1, and SHALL require rx_data=0xC3 and parity_err=1; the same frame with PARITY=1 SHALL give parity_err=0.
REQ-041 The bench SHALL send 0x3C with the stop bit driven low, and SHALL require rx_data=0x3C and frame_err=1.
REQ-042 The bench SHALL hold rx_ready low and send 0x11 then 0x22, and SHALL require rx_data to stay 0x11 and overrun to pulse exactly 1 clock.
REQ-043 The bench SHALL drive a 100-clock low glitch on an idle line, and SHALL require no rx_valid and rx_busy to return low within 1 bit time.
REQ-044 The bench SHALL assert rst at bit 4 of a frame, and SHALL require rx_valid=0 and state IDLE after reset, and that a following 0x5A frame is received correctly.
